multicycle_control: RTL

Multicycle control FSM for the CPU datapath. It decodes the instruction register and sequences each instruction through fetch, decode, execute, memory and write-back. It drives the select and function inputs of the ALU execute stage (`ALU_Bin_sel`, `ALU_func`) and consumes that stage's `Zero` flag for branch resolution. It also drives register-file, PC, instruction-register and data-memory enables, and waits on a data-memory acknowledge handshake.

---
 rtl/multicycle_control.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM.
// Sequences each instruction through IF / DEC / EXEC / MEM_* / WB_* / BRANCH,
// drives the ALU select/function inputs and the RF, PC, IR and data-memory
// enables, and waits on the data-memory acknowledge handshake.
// Optional feature macro: MC_PERF_CNT_EN adds the Cycle_cnt / Retired_cnt
// performance counters and their ports.
module multicycle_control (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_ack,
  output logic        IR_WrEn,
  output logic        PC_WrEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_RdEn,
  output logic        Mem_WrEn,
  output logic        Byte_op,
  output logic        Instr_done,
  output logic        Illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] Cycle_cnt,
  output logic [31:0] Retired_cnt
`endif
);

  // FSM state encoding
  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_DEC      = 4'd1;
  localparam logic [3:0] S_EXEC     = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_WB_ALU   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_B     = 6'b111111;

  // ALU function codes
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       r_started;
  logic [5:0] r_op;
  logic [3:0] r_func;
  logic [5:0] w_dec_op;
  logic [4:0] w_alu_ctrl;
  logic       w_unused_instr;

  assign w_dec_op       = Instr[31:26];
  assign w_unused_instr = ^Instr[25:4];

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: is_alu_op = 1'b1;
      default:                            is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LW: is_load = 1'b1;
      default:      is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SW: is_store = 1'b1;
      default:      is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_B: is_branch = 1'b1;
      default:              is_branch = 1'b0;
    endcase
  endfunction

  // Stores need rd as write data; beq/bne compare against rd.
  function automatic logic uses_rd(input logic [5:0] op);
    case (op)
      OP_SB, OP_SW, OP_BEQ, OP_BNE: uses_rd = 1'b1;
      default:                      uses_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: is_byte = 1'b1;
      default:      is_byte = 1'b0;
    endcase
  endfunction

  // Returns {ALU_Bin_sel, ALU_func} for the instruction's own ALU usage.
  function automatic logic [4:0] alu_ctrl(input logic [5:0] op, input logic [3:0] func);
    case (op)
      OP_RTYPE:                      alu_ctrl = {1'b0, func};
      OP_ADDI:                       alu_ctrl = {1'b1, FN_ADD};
      OP_ANDI:                       alu_ctrl = {1'b1, FN_AND};
      OP_ORI:                        alu_ctrl = {1'b1, FN_OR};
      OP_LB, OP_LW, OP_SB, OP_SW:    alu_ctrl = {1'b1, FN_ADD};
      OP_BEQ, OP_BNE, OP_B:          alu_ctrl = {1'b0, FN_SUB};
      default:                       alu_ctrl = 5'b0_0000;
    endcase
  endfunction

  assign w_alu_ctrl = alu_ctrl(r_op, r_func);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wake flag: keeps all outputs low until the first edge after reset release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Capture opcode and R-type function in DEC so later Instr changes are ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op   <= 6'd0;
      r_func <= 4'd0;
    end else if (r_started && (r_state == S_DEC)) begin
      r_op   <= w_dec_op;
      r_func <= Instr[3:0];
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IF: begin
        if (r_started) begin
          w_next_state = S_DEC;
        end else begin
          w_next_state = S_IF;
        end
      end
      S_DEC: begin
        if (is_alu_op(w_dec_op)) begin
          w_next_state = S_EXEC;
        end else if (is_load(w_dec_op) || is_store(w_dec_op)) begin
          w_next_state = S_MEM_ADDR;
        end else if (is_branch(w_dec_op)) begin
          w_next_state = S_BRANCH;
        end else begin
          w_next_state = S_IF;
        end
      end
      S_EXEC:   w_next_state = S_WB_ALU;
      S_WB_ALU: w_next_state = S_IF;
      S_MEM_ADDR: begin
        if (is_load(r_op)) begin
          w_next_state = S_MEM_RD;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (Mem_ack) begin
          w_next_state = S_WB_MEM;
        end else begin
          w_next_state = S_MEM_RD;
        end
      end
      S_WB_MEM: w_next_state = S_IF;
      S_MEM_WR: begin
        if (Mem_ack) begin
          w_next_state = S_IF;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_BRANCH: w_next_state = S_IF;
      default:  w_next_state = S_IF;
    endcase
  end

  // Output decode: Moore on state/opcode, except branch PC_sel (Zero) and
  // store completion (Mem_ack). All low until the wake flag is set.
  always_comb begin
    IR_WrEn       = 1'b0;
    PC_WrEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    Byte_op       = 1'b0;
    Instr_done    = 1'b0;
    Illegal       = 1'b0;
    if (r_started) begin
      case (r_state)
        S_IF: begin
          IR_WrEn = 1'b1;
        end
        S_DEC: begin
          RF_B_sel = uses_rd(w_dec_op);
          if (!(is_alu_op(w_dec_op) || is_load(w_dec_op) ||
                is_store(w_dec_op) || is_branch(w_dec_op))) begin
            Illegal = 1'b1;
            PC_WrEn = 1'b1;
          end else begin
            Illegal = 1'b0;
          end
        end
        S_EXEC: begin
          {ALU_Bin_sel, ALU_func} = w_alu_ctrl;
        end
        S_WB_ALU: begin
          {ALU_Bin_sel, ALU_func} = w_alu_ctrl;
          RF_WrEn    = 1'b1;
          PC_WrEn    = 1'b1;
          Instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          RF_B_sel    = uses_rd(r_op);
          ALU_Bin_sel = 1'b1;
          ALU_func    = FN_ADD;
          Byte_op     = is_byte(r_op);
        end
        S_MEM_RD: begin
          {ALU_Bin_sel, ALU_func} = w_alu_ctrl;
          Mem_RdEn = 1'b1;
          Byte_op  = is_byte(r_op);
        end
        S_WB_MEM: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
          PC_WrEn       = 1'b1;
          Instr_done    = 1'b1;
          Byte_op       = is_byte(r_op);
        end
        S_MEM_WR: begin
          {ALU_Bin_sel, ALU_func} = w_alu_ctrl;
          RF_B_sel   = uses_rd(r_op);
          Mem_WrEn   = 1'b1;
          Byte_op    = is_byte(r_op);
          PC_WrEn    = Mem_ack;
          Instr_done = Mem_ack;
        end
        S_BRANCH: begin
          RF_B_sel    = uses_rd(r_op);
          ALU_Bin_sel = 1'b0;
          ALU_func    = FN_SUB;
          PC_WrEn     = 1'b1;
          Instr_done  = 1'b1;
          case (r_op)
            OP_BEQ:  PC_sel = Zero;
            OP_BNE:  PC_sel = ~Zero;
            OP_B:    PC_sel = 1'b1;
            default: PC_sel = 1'b0;
          endcase
        end
        default: begin
          IR_WrEn = 1'b0;
        end
      endcase
    end else begin
      IR_WrEn = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retired_cnt;

  // Free-running cycle counter and retired-instruction counter (wrap at 2^32).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cycle_cnt   <= 32'd0;
      r_retired_cnt <= 32'd0;
    end else if (r_started) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (Instr_done) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign Cycle_cnt   = r_cycle_cnt;
  assign Retired_cnt = r_retired_cnt;
`endif

endmodule
